// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch front end.
//   Owns the fetch PC, issues pipelined requests to instruction memory, buffers returned words in an
//   in-order prefetch queue and presents {instr, pc, pc+4} to decode with a valid/ready handshake.
//   A redirect flushes the queue and discards responses for requests already in flight.
//
// Ports
//   clk_i           clock, rising edge
//   rst_i           synchronous reset, active-high
//   imem_req_o      request valid
//   imem_addr_o     request address (word aligned)
//   imem_gnt_i      request accepted this cycle
//   imem_rvalid_i   response valid (in issue order, at least one cycle after issue)
//   imem_rdata_i    response instruction word
//   redirect_i      branch taken / jump this cycle
//   redirect_pc_i   new PC, low two bits ignored
//   instr_valid_o   queue head valid
//   instr_ready_i   decode accepts the head
//   instr_o         head instruction
//   instr_pc_o      PC of head instruction
//   instr_pc4_o     instr_pc_o + 4 (wrapping)

module fetch_unit #(
    parameter int unsigned      XLEN     = 32,
    parameter int unsigned      DEPTH    = 4,
    parameter int unsigned      MAX_OUT  = 2,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [31:0]     imem_rdata_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            instr_valid_o,
    input  logic            instr_ready_i,
    output logic [31:0]     instr_o,
    output logic [XLEN-1:0] instr_pc_o,
    output logic [XLEN-1:0] instr_pc4_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    localparam logic [CntW:0]   DepthW  = DEPTH[CntW:0];
    localparam logic [CntW-1:0] MaxOutW = MAX_OUT[CntW-1:0];

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] resp_pc_q, resp_pc_d;
    logic [CntW-1:0] out_q, out_d;
    logic [CntW-1:0] kill_q, kill_d;
    logic [CntW-1:0] count_q, count_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;

    logic [31:0]     data_q [DEPTH];
    logic [XLEN-1:0] pcs_q  [DEPTH];

    logic [CntW:0]   used;
    logic [XLEN-1:0] redirect_aligned;
    logic            issue;
    logic            enq;
    logic            deq;

    // Requests in flight already own a queue slot, so the queue can never overflow.
    assign used             = {1'b0, count_q} + {1'b0, out_q};
    assign redirect_aligned = redirect_pc_i & ~XLEN'(3);

    assign imem_req_o  = !rst_i && !redirect_i && (used < DepthW) && (out_q < MaxOutW);
    assign imem_addr_o = fetch_pc_q;
    assign issue       = imem_req_o && imem_gnt_i;

    // A response is kept only if it is not owed to an earlier redirect and does not land in one.
    assign enq = imem_rvalid_i && (kill_q == '0) && !redirect_i;
    assign deq = instr_valid_o && instr_ready_i && !redirect_i;

    assign instr_valid_o = (count_q != '0);
    assign instr_o       = data_q[rd_ptr_q];
    assign instr_pc_o    = pcs_q[rd_ptr_q];
    assign instr_pc4_o   = instr_pc_o + XLEN'(4);

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        out_d      = out_q;
        kill_d     = kill_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;

        if (issue) begin
            out_d = out_d + CntW'(1);
        end
        if (imem_rvalid_i) begin
            out_d = out_d - CntW'(1);
        end

        if (redirect_i) begin
            fetch_pc_d = redirect_aligned;
            resp_pc_d  = redirect_aligned;
            // Everything still outstanding after this cycle belongs to the old path.
            kill_d     = out_q - (imem_rvalid_i ? CntW'(1) : CntW'(0));
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
        end else begin
            if (issue) begin
                fetch_pc_d = fetch_pc_q + XLEN'(4);
            end
            if (imem_rvalid_i && (kill_q != '0)) begin
                kill_d = kill_q - CntW'(1);
            end
            if (enq) begin
                resp_pc_d = resp_pc_q + XLEN'(4);
                wr_ptr_d  = wr_ptr_q + PtrW'(1);
            end
            if (deq) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            if (enq && !deq) begin
                count_d = count_q + CntW'(1);
            end else if (!enq && deq) begin
                count_d = count_q - CntW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            out_q      <= '0;
            kill_q     <= '0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            out_q      <= out_d;
            kill_q     <= kill_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    // Storage is cleared on reset so the head outputs read zero until the first word arrives.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                data_q[PtrW'(i)] <= '0;
                pcs_q[PtrW'(i)]  <= '0;
            end
        end else if (enq) begin
            data_q[wr_ptr_q] <= imem_rdata_i;
            pcs_q[wr_ptr_q]  <= resp_pc_q;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: instruction memory model with configurable latency, directed scenarios,
// and a scoreboard of expected PCs checked by an independent monitor on every accepted instruction.

module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b1;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] instr_pc4;

    always #5 clk = ~clk;

    fetch_unit #(
        .XLEN     (32),
        .DEPTH    (4),
        .MAX_OUT  (2),
        .RESET_PC (32'h100)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .imem_req_o    (imem_req),
        .imem_addr_o   (imem_addr),
        .imem_gnt_i    (imem_gnt),
        .imem_rvalid_i (imem_rvalid),
        .imem_rdata_i  (imem_rdata),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .instr_valid_o (instr_valid),
        .instr_ready_i (instr_ready),
        .instr_o       (instr),
        .instr_pc_o    (instr_pc),
        .instr_pc4_o   (instr_pc4)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_q[$];
    logic        ready_en = 1'b0;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    req_t inflight[$];
    int   cyc = 0;
    int   lat = 1;
    int   issue_cnt = 0;

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Memory model: in-order responses, each 'lat' cycles after its issue.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            inflight.delete();
            imem_rvalid = 1'b0;
            imem_rdata  = '0;
        end else begin
            if (inflight.size() != 0 && inflight[0].due <= cyc) begin
                imem_rvalid = 1'b1;
                imem_rdata  = word(inflight[0].addr);
                inflight.delete(0);
            end else begin
                imem_rvalid = 1'b0;
                imem_rdata  = '0;
            end
            if (imem_req && imem_gnt) begin
                inflight.push_back('{addr: imem_addr, due: cyc + lat});
                issue_cnt++;
            end
        end
    end

    // Monitor: accepts only as many instructions as are expected; redirect-cycle pops are void.
    initial forever begin
        logic [31:0] e;
        @(negedge clk);
        instr_ready = ready_en && (exp_q.size() != 0);
        if (!rst && !redirect && instr_valid && instr_ready) begin
            e = exp_q.pop_front();
            chk("instr", instr, word(e));
            chk("instr_pc", instr_pc, e);
            chk("instr_pc4", instr_pc4, e + 32'd4);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        redirect = 1'b0;
        ready_en = 1'b0;
        exp_q.delete();
        repeat (2) step();
        issue_cnt = 0;
    endtask

    task automatic drain(input string name, input int max);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < max) begin
            step();
            n++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: %0d entries left, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        do_reset();
        settle();
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_pc", instr_pc, 32'd0);
        chk("rst_pc4", instr_pc4, 32'd4);

        // Streaming fetch with single-cycle memory
        lat      = 1;
        ready_en = 1'b1;
        for (int i = 0; i < 8; i++) exp_q.push_back(32'h100 + 32'(4 * i));
        rst = 1'b0;
        settle();
        chk("t1_req0", {31'b0, imem_req}, 32'd1);
        chk("t1_addr0", imem_addr, 32'h100);
        step();
        chk("t1_addr1", imem_addr, 32'h104);
        step();
        chk("t1_addr2", imem_addr, 32'h108);
        drain("t1", 40);

        // Stall: queue plus in-flight fills to DEPTH, then drains in order
        do_reset();
        lat = 1;
        rst = 1'b0;
        repeat (10) step();
        chk("t2_req_stop", {31'b0, imem_req}, 32'd0);
        chk("t2_valid", {31'b0, instr_valid}, 32'd1);
        chk("t2_head_pc", instr_pc, 32'h100);
        chk("t2_head_instr", instr, word(32'h100));
        chk("t2_issues", 32'(issue_cnt), 32'd4);
        for (int i = 0; i < 6; i++) exp_q.push_back(32'h100 + 32'(4 * i));
        ready_en = 1'b1;
        drain("t2", 40);

        // Redirect with two slow requests in flight
        do_reset();
        lat      = 3;
        ready_en = 1'b1;
        exp_q.push_back(32'h200);
        exp_q.push_back(32'h204);
        exp_q.push_back(32'h208);
        rst = 1'b0;
        settle();
        chk("t3_addr0", imem_addr, 32'h100);
        step();
        chk("t3_addr1", imem_addr, 32'h104);
        step();
        chk("t3_req_max_out", {31'b0, imem_req}, 32'd0);
        redirect    = 1'b1;
        redirect_pc = 32'h203;
        step();
        redirect = 1'b0;
        settle();
        chk("t3_addr_redir", imem_addr, 32'h200);
        drain("t3", 60);

        // Redirect coinciding with a response and a pop
        do_reset();
        lat      = 1;
        ready_en = 1'b1;
        exp_q.push_back(32'h300);
        exp_q.push_back(32'h304);
        rst = 1'b0;
        settle();
        step();
        step();
        chk("t4_valid_pre", {31'b0, instr_valid}, 32'd1);
        chk("t4_pc_pre", instr_pc, 32'h100);
        redirect    = 1'b1;
        redirect_pc = 32'h300;
        step();
        redirect = 1'b0;
        settle();
        chk("t4_valid_post", {31'b0, instr_valid}, 32'd0);
        chk("t4_req_post", {31'b0, imem_req}, 32'd1);
        chk("t4_addr_post", imem_addr, 32'h300);
        drain("t4", 40);

        // Address wrap at the top of the address space
        do_reset();
        lat      = 1;
        ready_en = 1'b1;
        exp_q.push_back(32'hFFFF_FFF8);
        exp_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back(32'h0000_0000);
        exp_q.push_back(32'h0000_0004);
        rst         = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFB;
        settle();
        chk("t5_req_redir", {31'b0, imem_req}, 32'd0);
        step();
        redirect = 1'b0;
        settle();
        chk("t5_addr0", imem_addr, 32'hFFFF_FFF8);
        step();
        chk("t5_addr1", imem_addr, 32'hFFFF_FFFC);
        step();
        chk("t5_addr_wrap", imem_addr, 32'h0000_0000);
        drain("t5", 40);

        // Reset mid-operation with words queued and requests in flight
        do_reset();
        lat = 2;
        rst = 1'b0;
        settle();
        repeat (5) step();
        chk("t6_valid_pre", {31'b0, instr_valid}, 32'd1);
        chk("t6_req_pre", {31'b0, imem_req}, 32'd0);
        rst = 1'b1;
        settle();
        chk("t6_req_in_rst", {31'b0, imem_req}, 32'd0);
        step();
        chk("t6_valid_rst", {31'b0, instr_valid}, 32'd0);
        chk("t6_instr_rst", instr, 32'd0);
        chk("t6_pc_rst", instr_pc, 32'd0);
        chk("t6_pc4_rst", instr_pc4, 32'd4);
        chk("t6_req_rst", {31'b0, imem_req}, 32'd0);
        rst = 1'b0;
        settle();
        chk("t6_req_rel", {31'b0, imem_req}, 32'd1);
        chk("t6_addr_rel", imem_addr, 32'h100);
        exp_q.push_back(32'h100);
        exp_q.push_back(32'h104);
        exp_q.push_back(32'h108);
        ready_en = 1'b1;
        drain("t6", 40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
